alu_muldiv_ctrl: RTL
====================

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width in bits (legal range 4..64).
REQ-002 The block SHALL have a single clock, clk (input, 1), with all state updating on its rising edge.
REQ-003 The block SHALL have reset rst (input, 1), which is synchronous and active-high.
REQ-004 The block SHALL have input valid_in (1), meaning an instruction is presented this cycle.
REQ-005 The block SHALL have input alu_op (2): 00 ADDI, 01 SLTI, 10 R-type, 11 bitwise I-type.
REQ-006 The block SHALL have input funct (6), carrying the R-type funct field, or the opcode when alu_op=11.
REQ-007 The block SHALL have inputs a and b (WIDTH each), the rs and rt operands.
REQ-008 The block SHALL have output alu_control (4), the ALU command.
REQ-009 The block SHALL have output illegal (1), flagging an undecodable instruction.
REQ-010 The block SHALL have output stall (1), requesting a pipeline hold.
REQ-011 The block SHALL have output busy (1), meaning the multiply/divide engine is running.
REQ-012 The block SHALL have output done (1), a one-cycle completion pulse.
REQ-013 The block SHALL have outputs hi and lo (WIDTH each), the architectural HI and LO registers.
REQ-014 The block SHALL have output result (WIDTH), the MFHI/MFLO read data.

Function
REQ-015 Decode SHALL be combinational: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 0111.
REQ-016 alu_op=00 SHALL give 0010, and alu_op=01 SHALL give 0111, independent of funct.
REQ-017 alu_op=10 SHALL map funct as follows: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 101010 SLT, 010000 MFHI, 010010 MFLO, 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
REQ-018 alu_op=11 SHALL map opcode as follows: 001100 AND, 001101 OR, 001110 XOR.
REQ-019 MFHI and MFLO SHALL give alu_control 1000; MULT, MULTU, DIV and DIVU SHALL give 1001.
REQ-020 Any other combination SHALL give alu_control 1111, with illegal = valid_in.
REQ-021 result SHALL be hi for MFHI, lo for MFLO, and 0 otherwise.
REQ-022 The FSM SHALL have states IDLE, ITER, FIX.
REQ-023 In IDLE, a MULT/MULTU/DIV/DIVU with valid_in=1 SHALL be accepted on that edge: operands latched (absolute values for signed ops, signs saved), count=WIDTH, state to ITER.
REQ-024 ITER SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, decrementing count, and SHALL go to FIX after exactly WIDTH steps.
REQ-025 FIX SHALL apply the sign correction and write hi/lo on its exit edge, then return to IDLE with done=1 for exactly the following cycle.
REQ-026 Latency SHALL be fixed: done is high in cycle WIDTH+2 after the accepting edge; hi/lo hold the new values in that same cycle.
REQ-027 busy SHALL be 1 in ITER and FIX, and 0 otherwise.
REQ-028 stall SHALL equal busy AND valid_in AND (instruction is MF*/MULT*/DIV*), combinationally; other instructions never stall.
REQ-029 A stalled instruction SHALL NOT be accepted; it is accepted in the first IDLE cycle in which it is still presented.
REQ-030 Multiply SHALL write the full 2*WIDTH product: hi = upper half, lo = lower half.
REQ-031 Divide SHALL write lo = quotient and hi = remainder; the remainder takes the sign of the dividend, and the quotient truncates toward zero.
REQ-032 Divide by zero SHALL write lo = all ones and hi = a, for both signed and unsigned divide.
REQ-033 Signed most-negative / -1 SHALL write lo = most-negative and hi = 0.
REQ-034 hi and lo SHALL change only on the FIX exit edge or on reset.

Reset
REQ-035 rst SHALL force the state to IDLE and set count, hi, lo, busy and done to 0 on the next edge, including mid-operation; an aborted operation never asserts done.
REQ-036 During rst, combinational decode outputs SHALL remain a function of their inputs only.

Verification
REQ-037 Decode: alu_op=10/funct=101010 -> 0111; alu_op=11/funct=001110 -> 0011; alu_op=10/funct=111111 with valid_in=1 -> 1111, illegal=1.
REQ-038 MULTU with WIDTH=32, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, done exactly 34 cycles after accept.
REQ-039 MULT a=FFFFFFFD (-3), b=7 -> hi=FFFFFFFF, lo=FFFFFFEB.
REQ-040 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=5, b=0 -> lo=FFFFFFFF, hi=00000005.
REQ-041 MFLO presented while busy -> stall=1 every cycle until done, then result equals the new lo; an ADD presented while busy -> stall=0.
REQ-042 rst asserted in the 10th ITER cycle of a MULT -> busy=0, hi=lo=0 next cycle, and no done pulse thereafter.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus an iterative multiply/divide engine that owns the HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle; fixed latency.
module alu_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               dec_ok;
    logic               is_md;
    logic               md_div;
    logic               md_signed;
    logic               sel_hi;
    logic               sel_lo;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        alu_control = 4'b1111;
        dec_ok      = 1'b0;
        is_md       = 1'b0;
        md_div      = 1'b0;
        md_signed   = 1'b0;
        sel_hi      = 1'b0;
        sel_lo      = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_control = 4'b0010;
                dec_ok      = 1'b1;
            end
            2'b01: begin
                alu_control = 4'b0111;
                dec_ok      = 1'b1;
            end
            2'b10: begin
                dec_ok = 1'b1;
                case (funct)
                    6'b100000: alu_control = 4'b0010;
                    6'b100010: alu_control = 4'b0110;
                    6'b100100: alu_control = 4'b0000;
                    6'b100101: alu_control = 4'b0001;
                    6'b100110: alu_control = 4'b0011;
                    6'b101010: alu_control = 4'b0111;
                    6'b010000: begin
                        alu_control = 4'b1000;
                        sel_hi      = 1'b1;
                    end
                    6'b010010: begin
                        alu_control = 4'b1000;
                        sel_lo      = 1'b1;
                    end
                    6'b011000: begin
                        alu_control = 4'b1001;
                        is_md       = 1'b1;
                        md_signed   = 1'b1;
                    end
                    6'b011001: begin
                        alu_control = 4'b1001;
                        is_md       = 1'b1;
                    end
                    6'b011010: begin
                        alu_control = 4'b1001;
                        is_md       = 1'b1;
                        md_div      = 1'b1;
                        md_signed   = 1'b1;
                    end
                    6'b011011: begin
                        alu_control = 4'b1001;
                        is_md       = 1'b1;
                        md_div      = 1'b1;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            default: begin
                dec_ok = 1'b1;
                case (funct)
                    6'b001100: alu_control = 4'b0000;
                    6'b001101: alu_control = 4'b0001;
                    6'b001110: alu_control = 4'b0011;
                    default:   dec_ok      = 1'b0;
                endcase
            end
        endcase
    end

    assign illegal = valid_in & ~dec_ok;
    assign busy    = (state_q != StIdle);
    assign stall   = busy & valid_in & (is_md | sel_hi | sel_lo);
    assign result  = sel_hi ? hi_q : (sel_lo ? lo_q : '0);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

    assign abs_a = (md_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (md_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: {acc, mq} shifts right, adding the multiplicand into the top half.
    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: remainder in acc, dividend shifts out of mq while quotient bits shift in.
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quot_fix = div0_q ? '1 : (neg_res_q ? -mq_q : mq_q);
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_in && is_md) begin
                    state_d   = StIter;
                    count_d   = CW'(WIDTH);
                    acc_d     = '0;
                    mq_d      = abs_a;
                    opnd_d    = abs_b;
                    is_div_d  = md_div;
                    neg_res_d = md_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = md_signed & a[WIDTH-1];
                    div0_d    = (b == '0);
                end
            end
            StIter: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule
